// File: rtl/mult_div_unit_pkg.sv
// Shared operation encodings and decode helpers for the iterative multiply/divide unit.
package mult_div_unit_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_divide_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module mdu_divide_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted_s;
    logic [WIDTH+1:0] diff_s;

    // Trial subtraction; a borrow out of the top bit means the divisor did not fit.
    always_comb begin
        shifted_s = {rem, dividend_bit};
        diff_s    = shifted_s - {2'b00, divisor};
        q_bit     = ~diff_s[WIDTH+1];
        if (q_bit) begin
            rem_next = diff_s[WIDTH:0];
        end else begin
            rem_next = shifted_s[WIDTH:0];
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: shift-add multiply, restoring divide, one bit per cycle.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t             state_r;
    logic [CW-1:0]      cnt_r;
    logic [2*WIDTH:0]   acc_r;
    logic [WIDTH:0]     rem_r;
    logic [WIDTH-1:0]   quo_r;
    logic [WIDTH-1:0]   opb_r;
    logic               is_div_r;
    logic               neg_res_r;
    logic               neg_rem_r;
    logic               div_zero_r;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic               signed_op_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH:0]   acc_next_s;
    logic [WIDTH:0]     div_rem_s;
    logic               div_q_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] mul_res_s;
    logic [WIDTH-1:0]   quo_res_s;
    logic [WIDTH-1:0]   rem_res_s;

    mdu_divide_step #(.WIDTH(WIDTH)) u_divide_step (
        .rem          (rem_r),
        .dividend_bit (quo_r[WIDTH-1]),
        .divisor      (opb_r),
        .rem_next     (div_rem_s),
        .q_bit        (div_q_s)
    );

    // Operand magnitudes, multiply iteration and final sign correction.
    // Negating the most negative value wraps to 2^(WIDTH-1), its correct unsigned magnitude.
    always_comb begin
        signed_op_s = op_is_signed(op);
        a_mag_s     = (signed_op_s && A[WIDTH-1]) ? -A : A;
        b_mag_s     = (signed_op_s && B[WIDTH-1]) ? -B : B;
        mul_sum_s   = acc_r[2*WIDTH:WIDTH] + (acc_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});
        acc_next_s  = {1'b0, mul_sum_s, acc_r[WIDTH-1:1]};
        prod_s      = acc_r[2*WIDTH-1:0];
        mul_res_s   = neg_res_r ? -prod_s : prod_s;
        rem_res_s   = neg_rem_r ? -rem_r[WIDTH-1:0] : rem_r[WIDTH-1:0];
        if (div_zero_r) begin
            quo_res_s = {WIDTH{1'b1}};
        end else begin
            quo_res_s = neg_res_r ? -quo_r : quo_r;
        end
    end

    // Control FSM, datapath registers and architectural HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CW{1'b0}};
            acc_r      <= {(2*WIDTH+1){1'b0}};
            rem_r      <= {(WIDTH+1){1'b0}};
            quo_r      <= {WIDTH{1'b0}};
            opb_r      <= {WIDTH{1'b0}};
            is_div_r   <= 1'b0;
            neg_res_r  <= 1'b0;
            neg_rem_r  <= 1'b0;
            div_zero_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start && !flush) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                state_r    <= ST_RUN;
                                busy_r     <= 1'b1;
                                cnt_r      <= CW'(WIDTH);
                                acc_r      <= {{(WIDTH+1){1'b0}}, a_mag_s};
                                quo_r      <= a_mag_s;
                                rem_r      <= {(WIDTH+1){1'b0}};
                                opb_r      <= b_mag_s;
                                is_div_r   <= op_is_div(op);
                                neg_res_r  <= signed_op_s & (A[WIDTH-1] ^ B[WIDTH-1]);
                                neg_rem_r  <= signed_op_s & A[WIDTH-1];
                                div_zero_r <= op_is_div(op) & (B == {WIDTH{1'b0}});
                            end
                            OP_MTHI: hi_r <= A;
                            OP_MTLO: lo_r <= A;
                            default: state_r <= ST_IDLE;
                        endcase
                    end
                end
                ST_RUN: begin
                    done_r <= 1'b0;
                    if (flush) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                        if (is_div_r) begin
                            rem_r <= div_rem_s;
                            quo_r <= {quo_r[WIDTH-2:0], div_q_s};
                        end else begin
                            acc_r <= acc_next_s;
                        end
                        if (cnt_r == CW'(1)) begin
                            state_r <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    if (flush) begin
                        done_r <= 1'b0;
                    end else begin
                        done_r <= 1'b1;
                        if (is_div_r) begin
                            hi_r <= rem_res_s;
                            lo_r <= quo_res_s;
                        end else begin
                            hi_r <= mul_res_s[2*WIDTH-1:WIDTH];
                            lo_r <= mul_res_s[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO and done cycle, a monitor checks each done pulse.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc       = 0;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   n_busy;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_done: done=1 at cycle %0d with nothing pending", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("done_hi", hi, mon_e.hi);
                check("done_lo", lo, mon_e.lo);
                check("done_cycle", cyc, mon_e.cyc);
            end
        end
    end

    // Present a one-cycle start; returns #1 after the edge that samples it.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count remaining busy cycles, bounded; returns in the first non-busy cycle.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mdu_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        int n;
        sb_q.push_back('{hi: exp_hi, lo: exp_lo, cyc: cyc + W + 2});
        issue(o, a, b);
        wait_idle(n);
        check("busy_cycles", n, W + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'd0;
        A     = '0;
        B     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        reset = 1'b0;

        // Back-to-back arithmetic: each start lands in the previous done cycle.
        mdu_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        mdu_op(3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        mdu_op(3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        mdu_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        mdu_op(3'd3, 32'd100,       32'd7,         32'd2,         32'd14);
        mdu_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        mdu_op(3'd2, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF);
        mdu_op(3'd3, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF);
        mdu_op(3'd2, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

        issue(3'd4, 32'h0000_CAFE, 32'h0);
        check("mthi_hi", hi, 32'h0000_CAFE);
        check("mthi_busy", busy, 1'b0);
        issue(3'd5, 32'h0000_BEEF, 32'h0);
        check("mtlo_lo", lo, 32'h0000_BEEF);
        check("mtlo_hi", hi, 32'h0000_CAFE);
        check("mtlo_busy", busy, 1'b0);

        // MTLO while busy is ignored; HI/LO hold until the final edge.
        sb_q.push_back('{hi: 32'd2, lo: 32'd14, cyc: cyc + W + 2});
        issue(3'd3, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        #1;
        issue(3'd5, 32'h0000_DEAD, 32'h0);
        check("midrun_lo_hold", lo, 32'h0000_BEEF);
        check("midrun_hi_hold", hi, 32'h0000_CAFE);
        check("midrun_busy", busy, 1'b1);
        wait_idle(n_busy);
        check("midrun_busy_left", n_busy, 27);

        issue(3'd0, 32'd3, 32'd5);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", busy, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        check("flush_hi", hi, 32'd2);
        check("flush_lo", lo, 32'd14);

        issue(3'd0, 32'd3, 32'd5);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_hi", hi, 32'h0);
        check("rst_mid_lo", lo, 32'h0);
        repeat (40) @(posedge clk);
        #1;

        flush = 1'b1;
        issue(3'd0, 32'd3, 32'd5);
        check("startflush_busy", busy, 1'b0);
        issue(3'd4, 32'h0000_ABCD, 32'h0);
        flush = 1'b0;
        check("startflush_mthi", hi, 32'h0);
        check("startflush_busy2", busy, 1'b0);

        issue(3'd6, 32'h1111_1111, 32'h2222_2222);
        check("unused_op_busy", busy, 1'b0);
        check("unused_op_hi", hi, 32'h0);
        check("unused_op_lo", lo, 32'h0);

        mdu_op(3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
